// File: rtl/mac_recv_pkg.sv
// Shared constants and types for the receive MAC and its CRC helper.
package mac_recv_pkg;

  // Reflected CRC-32 (IEEE 802.3), processed LSB-first.
  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  // Register value left after data plus a correct FCS, with no final XOR applied.
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  localparam logic [47:0] BcastMac = 48'hFFFF_FFFF_FFFF;

  localparam int unsigned MinFrameDefault = 64;
  localparam int unsigned MaxFrameDefault = 1518;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StDrop,
    StDone
  } rx_state_e;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32; shared with the transmit side.
module crc32_byte
  import mac_recv_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  // Eight LSB-first shift/XOR steps unrolled into one cycle.
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CrcPoly) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/mac_recv.sv
// Receive MAC: header parse, destination filter, FCS strip, CRC and length check.
module mac_recv
  import mac_recv_pkg::*;
#(
  parameter int unsigned MIN_FRAME = MinFrameDefault,
  parameter int unsigned MAX_FRAME = MaxFrameDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  rx_byte,
  input  logic [47:0] local_mac,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_ethertype,
  output logic        rx_broadcast,
  output logic [10:0] rx_length,
  output logic        rx_done,
  output logic        rx_good
);

  rx_state_e       state_q, state_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d, crc_base, crc_next;
  logic            en_q;
  logic            ucast_q, ucast_d, bcast_q, bcast_d;
  logic            ucast_hit, bcast_hit;
  logic [7:0]      local_byte;
  logic [3:0][7:0] dl_q, dl_d;
  logic [2:0]      dl_cnt_q, dl_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic [47:0]     src_q, src_d;
  logic [15:0]     type_q, type_d;
  logic            brd_q, brd_d;
  logic [10:0]     len_q, len_d;
  logic            good_q, good_d;

  // A new frame starts from a fresh CRC; mid-frame bytes continue the running value.
  assign crc_base = (state_q == StIdle) ? CrcInit : crc_q;

  crc32_byte u_crc (
    .crc      (crc_base),
    .data     (rx_byte),
    .crc_next (crc_next)
  );

  // Station address byte matching the current destination byte index.
  always_comb begin
    case (cnt_q[2:0])
      3'd0:    local_byte = local_mac[47:40];
      3'd1:    local_byte = local_mac[39:32];
      3'd2:    local_byte = local_mac[31:24];
      3'd3:    local_byte = local_mac[23:16];
      3'd4:    local_byte = local_mac[15:8];
      3'd5:    local_byte = local_mac[7:0];
      default: local_byte = 8'h00;
    endcase
  end

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    ucast_d  = ucast_q;
    bcast_d  = bcast_q;
    dl_d     = dl_q;
    dl_cnt_d = dl_cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    src_d    = src_q;
    type_d   = type_q;
    brd_d    = brd_q;
    len_d    = len_q;
    good_d   = 1'b0;

    ucast_hit = ((cnt_q == '0) || ucast_q) && (rx_byte == local_byte);
    bcast_hit = ((cnt_q == '0) || bcast_q) && (rx_byte == BcastMac[7:0]);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Rising edge only, so a frame cut by reset is not re-entered mid-stream.
        if (rx_enable && !en_q) begin
          cnt_d    = 11'd1;
          crc_d    = crc_next;
          ucast_d  = ucast_hit;
          bcast_d  = bcast_hit;
          dl_cnt_d = '0;
          len_d    = '0;
          brd_d    = 1'b0;
          state_d  = StHdr;
        end
      end
      StHdr: begin
        if (rx_enable) begin
          cnt_d = cnt_q + 11'd1;
          crc_d = crc_next;
          if (cnt_q < 11'd6) begin
            ucast_d = ucast_hit;
            bcast_d = bcast_hit;
          end
          if (cnt_q == 11'd5) begin
            if (!ucast_hit && !bcast_hit) state_d = StDrop;
            else brd_d = bcast_hit;
          end
          if (cnt_q >= 11'd6 && cnt_q <= 11'd11) src_d = {src_q[39:0], rx_byte};
          if (cnt_q == 11'd12 || cnt_q == 11'd13) type_d = {type_q[7:0], rx_byte};
          if (cnt_q == 11'd13) state_d = StPayload;
        end else begin
          // Truncated header: report only if the address had already matched.
          state_d = (cnt_q >= 11'd6) ? StDone : StIdle;
        end
      end
      StPayload: begin
        if (rx_enable) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;
          crc_d = crc_next;
          dl_d  = {dl_q[2:0], rx_byte};
          // Oldest byte leaves only once four newer ones exist; the last four are FCS.
          if (dl_cnt_q == 3'd4) begin
            valid_d = 1'b1;
            data_d  = dl_q[3];
            len_d   = (len_q == '1) ? len_q : len_q + 11'd1;
          end else begin
            dl_cnt_d = dl_cnt_q + 3'd1;
          end
        end else begin
          state_d = StDone;
          good_d  = (crc_q == CrcResidue) && (cnt_q >= 11'(MIN_FRAME)) &&
                    (cnt_q <= 11'(MAX_FRAME));
        end
      end
      StDrop: begin
        if (!rx_enable) state_d = StIdle;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      crc_q    <= CrcInit;
      // Treat the line as busy so a frame in flight at reset is ignored until it ends.
      en_q     <= 1'b1;
      ucast_q  <= 1'b0;
      bcast_q  <= 1'b0;
      dl_q     <= '0;
      dl_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      src_q    <= '0;
      type_q   <= '0;
      brd_q    <= 1'b0;
      len_q    <= '0;
      good_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      en_q     <= rx_enable;
      ucast_q  <= ucast_d;
      bcast_q  <= bcast_d;
      dl_q     <= dl_d;
      dl_cnt_q <= dl_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      src_q    <= src_d;
      type_q   <= type_d;
      brd_q    <= brd_d;
      len_q    <= len_d;
      good_q   <= good_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_src_mac   = src_q;
  assign rx_ethertype = type_q;
  assign rx_broadcast = brd_q;
  assign rx_length    = len_q;
  assign rx_done      = (state_q == StDone);
  assign rx_good      = good_q;

endmodule

// File: tb/tb_mac_recv.sv
// Directed scoreboard bench for mac_recv.
module tb_mac_recv;

  logic        clock;
  logic        reset;
  logic        rx_enable;
  logic [7:0]  rx_byte;
  logic [47:0] local_mac;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [47:0] rx_src_mac;
  logic [15:0] rx_ethertype;
  logic        rx_broadcast;
  logic [10:0] rx_length;
  logic        rx_done;
  logic        rx_good;

  typedef struct {
    logic        good;
    int          len;
    logic        bcast;
    logic        hdr;
    logic [47:0] src;
    logic [15:0] etype;
  } stat_t;

  logic [7:0] exp_data[$];
  stat_t      exp_stat[$];
  logic [7:0] frm[$];

  int checks;
  int failures;

  logic [47:0] local_addr;
  logic [47:0] src_addr;
  logic [47:0] bcast_addr;
  logic [47:0] other_addr;

  mac_recv dut (
    .clock        (clock),
    .reset        (reset),
    .rx_enable    (rx_enable),
    .rx_byte      (rx_byte),
    .local_mac    (local_mac),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_src_mac   (rx_src_mac),
    .rx_ethertype (rx_ethertype),
    .rx_broadcast (rx_broadcast),
    .rx_length    (rx_length),
    .rx_done      (rx_done),
    .rx_good      (rx_good)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // One clock: drive inputs, step past the edge, then score the outputs.
  task automatic step(input logic en, input logic [7:0] b, input logic rst);
    stat_t s;
    rx_enable = en;
    rx_byte   = b;
    reset     = rst;
    @(posedge clock);
    #1;
    if (exp_data.size() != 0) begin
      chk("rx_valid", 64'(rx_valid), 64'd1);
      chk("rx_data", 64'(rx_data), 64'(exp_data.pop_front()));
    end else begin
      chk("rx_valid_spurious", 64'(rx_valid), 64'd0);
    end
    if (exp_stat.size() != 0) begin
      s = exp_stat.pop_front();
      chk("rx_done", 64'(rx_done), 64'd1);
      chk("rx_good", 64'(rx_good), 64'(s.good));
      chk("rx_length", 64'(rx_length), 64'(s.len));
      chk("rx_broadcast", 64'(rx_broadcast), 64'(s.bcast));
      if (s.hdr) begin
        chk("rx_src_mac", 64'(rx_src_mac), 64'(s.src));
        chk("rx_ethertype", 64'(rx_ethertype), 64'(s.etype));
      end
    end else begin
      chk("rx_done_spurious", 64'(rx_done), 64'd0);
    end
    if (rx_valid && rx_done) chk("valid_done_overlap", 64'(rx_valid & rx_done), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 64'(rx_valid), 64'd0);
    chk({tag, "_data"}, 64'(rx_data), 64'd0);
    chk({tag, "_done"}, 64'(rx_done), 64'd0);
    chk({tag, "_good"}, 64'(rx_good), 64'd0);
    chk({tag, "_length"}, 64'(rx_length), 64'd0);
    chk({tag, "_src"}, 64'(rx_src_mac), 64'd0);
    chk({tag, "_etype"}, 64'(rx_ethertype), 64'd0);
    chk({tag, "_bcast"}, 64'(rx_broadcast), 64'd0);
  endtask

  // Header, incrementing payload, then FCS (inverted CRC, LSB byte first).
  task automatic build_frame(input logic [47:0] dst, input int plen);
    logic [31:0] c;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src_addr[8*i +: 8]);
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    for (int i = 0; i < plen; i++) frm.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    foreach (frm[k]) c = crc_upd(c, frm[k]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  // Each payload byte is expected right after the edge of the byte four later.
  task automatic send_frame(input logic accept, input logic good, input logic bcast,
                            input int reset_at);
    int    n;
    logic  aborted;
    stat_t s;
    n = frm.size();
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == reset_at) aborted = 1'b1;
      else if (accept && !aborted && i >= 18) exp_data.push_back(frm[i-4]);
      step(1'b1, frm[i], i == reset_at);
      if (i == reset_at) check_cleared("reset_mid_frame");
    end
    if (accept && !aborted) begin
      s.good  = good;
      s.len   = (n >= 18) ? n - 18 : 0;
      s.bcast = bcast;
      s.hdr   = (n >= 14);
      s.src   = src_addr;
      s.etype = 16'h0800;
      exp_stat.push_back(s);
    end
    repeat (3) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    local_addr = 48'h00_11_22_33_44_55;
    src_addr   = 48'h66_77_88_99_AA_BB;
    bcast_addr = 48'hFF_FF_FF_FF_FF_FF;
    other_addr = 48'h02_00_00_00_00_01;
    local_mac  = local_addr;
    rx_enable  = 1'b0;
    rx_byte    = 8'h00;
    reset      = 1'b1;

    repeat (3) step(1'b0, 8'h00, 1'b1);
    check_cleared("reset_state");
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // 64-byte unicast, good FCS.
    build_frame(local_addr, 46);
    send_frame(1'b1, 1'b1, 1'b0, -1);

    // Same frame to broadcast.
    build_frame(bcast_addr, 46);
    send_frame(1'b1, 1'b1, 1'b1, -1);

    // Foreign destination: silently dropped.
    build_frame(other_addr, 46);
    send_frame(1'b0, 1'b0, 1'b0, -1);

    // One payload bit flipped after FCS computed.
    build_frame(local_addr, 46);
    frm[20] = frm[20] ^ 8'h01;
    send_frame(1'b1, 1'b0, 1'b0, -1);

    // Runt (60 bytes) and oversize (1519 bytes) with correct FCS.
    build_frame(local_addr, 42);
    send_frame(1'b1, 1'b0, 1'b0, -1);
    build_frame(local_addr, 1501);
    send_frame(1'b1, 1'b0, 1'b0, -1);

    // Frame cut inside the header after the address matched.
    build_frame(local_addr, 0);
    while (frm.size() > 10) void'(frm.pop_back());
    send_frame(1'b1, 1'b0, 1'b0, -1);

    // Reset at payload byte 20, then a clean frame.
    build_frame(local_addr, 46);
    send_frame(1'b1, 1'b1, 1'b0, 34);
    build_frame(local_addr, 46);
    send_frame(1'b1, 1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
